wb_retire: RTL and testbench

- Write-back/retire stage; consumes the registered bundle leaving the MEM/WB pipeline register.
- Drives the GPR write port and the CSR write port, and counts retired instructions.
- Debug (JTAG) GPR writes have priority on the shared GPR write port. Colliding pipeline writes park in a 2-entry buffer.
- While the buffer is occupied, the block requests a pipeline hold and exposes buffered data for operand lookup.

---
 rtl/wb_retire_pkg.sv | 25 ++
 rtl/wb_retire_if.sv | 51 +++++
 rtl/wb_wr_buf.sv | 93 +++++++++
 rtl/wb_retire.sv | 120 ++++++++++++
 tb/tb_wb_retire.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_retire_pkg.sv
// Shared constants and payload types for the write-back/retire stage.
package wb_retire_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned REG_W        = 32;
  localparam int unsigned INST_W       = 32;
  localparam int unsigned INST_ADDR_W  = 32;
  localparam int unsigned MEM_ADDR_W   = 32;
  localparam int unsigned HOLD_W       = 3;

  localparam int unsigned WB_BUF_DEPTH = 2;
  localparam int unsigned WB_BUF_PTR_W = $clog2(WB_BUF_DEPTH);

  // Canonical RISC-V nop: addi x0, x0, 0
  localparam logic [INST_W-1:0] INST_NOP  = 32'h0000_0013;
  localparam logic [HOLD_W-1:0] HOLD_NONE = 3'd0;
  localparam logic [HOLD_W-1:0] HOLD_MEM  = 3'd4;

  // One GPR write: destination register and value
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_W-1:0]      data;
  } gpr_wr_t;

endpackage

// File: rtl/wb_retire_if.sv
// Bundle, debug-write, lookup and result signals of the retire stage.
interface wb_retire_if #(
  parameter int unsigned CNT_W = 64
);
  import wb_retire_pkg::*;

  logic [INST_W-1:0]      inst_i;
  logic [INST_ADDR_W-1:0] inst_addr_i;
  logic                   reg_we_i;
  logic [REG_ADDR_W-1:0]  reg_waddr_i;
  logic [REG_W-1:0]       reg_wdata_i;
  logic                   csr_we_i;
  logic [MEM_ADDR_W-1:0]  csr_waddr_i;
  logic [REG_W-1:0]       csr_wdata_i;
  logic [HOLD_W-1:0]      hold_flag_i;
  logic                   jtag_we_i;
  logic [REG_ADDR_W-1:0]  jtag_addr_i;
  logic [REG_W-1:0]       jtag_data_i;
  logic [REG_ADDR_W-1:0]  lk_addr_i;

  logic                   rf_we_o;
  logic [REG_ADDR_W-1:0]  rf_waddr_o;
  logic [REG_W-1:0]       rf_wdata_o;
  logic                   csr_we_o;
  logic [MEM_ADDR_W-1:0]  csr_waddr_o;
  logic [REG_W-1:0]       csr_wdata_o;
  logic                   lk_hit_o;
  logic [REG_W-1:0]       lk_data_o;
  logic                   hold_req_o;
  logic                   retire_o;
  logic [INST_ADDR_W-1:0] retire_pc_o;
  logic [CNT_W-1:0]       instret_o;
  logic                   ovf_o;

  modport slave (
    input  inst_i, inst_addr_i, reg_we_i, reg_waddr_i, reg_wdata_i,
           csr_we_i, csr_waddr_i, csr_wdata_i, hold_flag_i,
           jtag_we_i, jtag_addr_i, jtag_data_i, lk_addr_i,
    output rf_we_o, rf_waddr_o, rf_wdata_o, csr_we_o, csr_waddr_o, csr_wdata_o,
           lk_hit_o, lk_data_o, hold_req_o, retire_o, retire_pc_o, instret_o, ovf_o
  );

  modport master (
    output inst_i, inst_addr_i, reg_we_i, reg_waddr_i, reg_wdata_i,
           csr_we_i, csr_waddr_i, csr_wdata_i, hold_flag_i,
           jtag_we_i, jtag_addr_i, jtag_data_i, lk_addr_i,
    input  rf_we_o, rf_waddr_o, rf_wdata_o, csr_we_o, csr_waddr_o, csr_wdata_o,
           lk_hit_o, lk_data_o, hold_req_o, retire_o, retire_pc_o, instret_o, ovf_o
  );

endinterface

// File: rtl/wb_wr_buf.sv
// GPR write buffer: small FIFO of parked pipeline writes with operand lookup
// and a sticky overflow flag. DEPTH must be a power of two.
module wb_wr_buf
  import wb_retire_pkg::*;
#(
  parameter int unsigned DEPTH = WB_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  gpr_wr_t               push_ent_i,
  input  logic                  pop_i,
  output gpr_wr_t               head_o,
  output logic                  empty_o,
  output logic                  busy_nxt_o,
  input  logic [REG_ADDR_W-1:0] lk_addr_i,
  output logic                  lk_hit_o,
  output logic [REG_W-1:0]      lk_data_o,
  output logic                  ovf_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  gpr_wr_t          mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             full, do_pop, do_push;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign head_o  = mem_q[rd_q];
  assign ovf_o   = ovf_q;

  // Pointer, occupancy and overflow next-state
  always_comb begin
    rd_d  = rd_q + PTR_W'(do_pop);
    wr_d  = wr_q + PTR_W'(do_push);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    ovf_d = ovf_q | (push_i && full && !do_pop);
  end

  assign busy_nxt_o = (cnt_d != '0);

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entry storage; occupancy count qualifies stale contents
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_ent_i;
    end
  end

  // Youngest-match lookup; an accepted same-cycle push counts as youngest
  always_comb begin
    logic [PTR_W-1:0] idx;
    lk_hit_o  = 1'b0;
    lk_data_o = '0;
    idx       = rd_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = rd_q + PTR_W'(i);
      if ((CW'(i) < cnt_q) && (mem_q[idx].addr == lk_addr_i)) begin
        lk_hit_o  = 1'b1;
        lk_data_o = mem_q[idx].data;
      end
    end
    if (do_push && (push_ent_i.addr == lk_addr_i)) begin
      lk_hit_o  = 1'b1;
      lk_data_o = push_ent_i.data;
    end
    if (lk_addr_i == '0) begin
      lk_hit_o  = 1'b0;
      lk_data_o = '0;
    end
  end

endmodule

// File: rtl/wb_retire.sv
// Write-back/retire stage: GPR write-port arbitration (debug first, then
// parked writes, then the live bundle), CSR pass-through, retire pulse and
// retired-instruction counter. Define WB_INSTRET_EN to build the counter.
module wb_retire
  import wb_retire_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = WB_BUF_DEPTH,
  parameter int unsigned CNT_W     = 64
) (
  input logic        clk,
  input logic        rst,
  wb_retire_if.slave bus
);

  logic       new_q, new_d;
  logic       hold_q, hold_d;
  logic       cand_c, rf_we_c, push_c, pop_c, retire_c, csr_we_c;
  logic       buf_empty, busy_nxt, buf_hit, buf_ovf;
  logic [REG_W-1:0] buf_data;
  gpr_wr_t    cand_ent, head_ent, rf_ent;

  assign cand_ent.addr = bus.reg_waddr_i;
  assign cand_ent.data = bus.reg_wdata_i;
  assign cand_c        = new_q && bus.reg_we_i && (bus.reg_waddr_i != '0);

  // Write-port priority mux and buffer push/pop control
  always_comb begin
    rf_we_c = 1'b0;
    rf_ent  = '0;
    push_c  = 1'b0;
    pop_c   = 1'b0;
    if (!rst) begin
      if (bus.jtag_we_i) begin
        rf_we_c     = 1'b1;
        rf_ent.addr = bus.jtag_addr_i;
        rf_ent.data = bus.jtag_data_i;
        push_c      = cand_c;
      end else if (!buf_empty) begin
        rf_we_c = 1'b1;
        rf_ent  = head_ent;
        pop_c   = 1'b1;
        push_c  = cand_c;
      end else if (cand_c) begin
        rf_we_c = 1'b1;
        rf_ent  = cand_ent;
      end
    end
  end

  wb_wr_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push_c),
    .push_ent_i (cand_ent),
    .pop_i      (pop_c),
    .head_o     (head_ent),
    .empty_o    (buf_empty),
    .busy_nxt_o (busy_nxt),
    .lk_addr_i  (bus.lk_addr_i),
    .lk_hit_o   (buf_hit),
    .lk_data_o  (buf_data),
    .ovf_o      (buf_ovf)
  );

  // New-bundle flag and hold request next-state
  always_comb begin
    new_d  = (bus.hold_flag_i < HOLD_MEM);
    hold_d = busy_nxt;
  end

  // New-bundle flag and hold request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      new_q  <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      new_q  <= new_d;
      hold_q <= hold_d;
    end
  end

  assign retire_c = !rst && new_q && (bus.inst_i != INST_NOP);
  assign csr_we_c = !rst && new_q && bus.csr_we_i;

  assign bus.rf_we_o     = rf_we_c;
  assign bus.rf_waddr_o  = rf_ent.addr;
  assign bus.rf_wdata_o  = rf_ent.data;
  assign bus.csr_we_o    = csr_we_c;
  assign bus.csr_waddr_o = csr_we_c ? bus.csr_waddr_i : '0;
  assign bus.csr_wdata_o = csr_we_c ? bus.csr_wdata_i : '0;
  assign bus.lk_hit_o    = !rst && buf_hit;
  assign bus.lk_data_o   = rst ? '0 : buf_data;
  assign bus.hold_req_o  = hold_q;
  assign bus.retire_o    = retire_c;
  assign bus.retire_pc_o = retire_c ? bus.inst_addr_i : '0;
  assign bus.ovf_o       = buf_ovf;

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;

  // Retired-instruction count next-state, wraps naturally
  always_comb begin
    instret_d = instret_q + CNT_W'(retire_c);
  end

  // Retired-instruction count register
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign bus.instret_o = instret_q;
`else
  assign bus.instret_o = CNT_W'(0);
`endif

endmodule

// File: tb/tb_wb_retire.sv
// Bench for wb_retire: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_wb_retire;
  import wb_retire_pkg::*;

  localparam int unsigned CNT_W = 64;
  localparam int unsigned DEPTH = WB_BUF_DEPTH;
  localparam int unsigned OUTW  = 171 + CNT_W;
`ifdef WB_INSTRET_EN
  localparam logic IR_EN = 1'b1;
`else
  localparam logic IR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_retire_if #(.CNT_W(CNT_W)) bus ();
  wb_retire #(.BUF_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model state
  gpr_wr_t          m_q[$];
  logic             m_new, m_hold, m_ovf;
  logic [CNT_W-1:0] m_ir;
  gpr_wr_t          m_cand;
  logic             m_push, m_pop, m_acc;
  // Expected combinational outputs
  logic        e_rf_we, e_csr_we, e_hit, e_ret;
  logic [4:0]  e_rf_addr;
  logic [31:0] e_rf_data, e_csr_addr, e_csr_data, e_lkd, e_pc;

  task automatic model_eval();
    logic cand;
    e_rf_we = 0; e_rf_addr = 0; e_rf_data = 0; e_csr_we = 0; e_csr_addr = 0; e_csr_data = 0;
    e_hit = 0; e_lkd = 0; e_ret = 0; e_pc = 0; m_push = 0; m_pop = 0; m_acc = 0;
    m_cand.addr = bus.reg_waddr_i;
    m_cand.data = bus.reg_wdata_i;
    if (!rst) begin
      cand = m_new && bus.reg_we_i && (bus.reg_waddr_i != 0);
      if (bus.jtag_we_i) begin
        e_rf_we = 1; e_rf_addr = bus.jtag_addr_i; e_rf_data = bus.jtag_data_i; m_push = cand;
      end else if (m_q.size() != 0) begin
        e_rf_we = 1; e_rf_addr = m_q[0].addr; e_rf_data = m_q[0].data; m_pop = 1; m_push = cand;
      end else if (cand) begin
        e_rf_we = 1; e_rf_addr = m_cand.addr; e_rf_data = m_cand.data;
      end
      m_acc = m_push && ((m_q.size() < int'(DEPTH)) || m_pop);
      if (bus.lk_addr_i != 0) begin
        foreach (m_q[i]) if (m_q[i].addr == bus.lk_addr_i) begin e_hit = 1; e_lkd = m_q[i].data; end
        if (m_acc && m_cand.addr == bus.lk_addr_i) begin e_hit = 1; e_lkd = m_cand.data; end
      end
      e_ret = m_new && (bus.inst_i != INST_NOP);
      e_pc  = e_ret ? bus.inst_addr_i : 32'h0;
      e_csr_we = m_new && bus.csr_we_i;
      if (e_csr_we) begin e_csr_addr = bus.csr_waddr_i; e_csr_data = bus.csr_wdata_i; end
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_q.delete(); m_new = 0; m_hold = 0; m_ovf = 0; m_ir = 0;
    end else begin
      if (m_pop) void'(m_q.pop_front());
      if (m_acc) m_q.push_back(m_cand);
      else if (m_push) m_ovf = 1;
      m_hold = (m_q.size() != 0);
      if (IR_EN && e_ret) m_ir = m_ir + 1;
      m_new = (bus.hold_flag_i < HOLD_MEM);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_idle();
    bus.inst_i = INST_NOP; bus.inst_addr_i = 0; bus.reg_we_i = 0; bus.reg_waddr_i = 0;
    bus.reg_wdata_i = 0; bus.csr_we_i = 0; bus.csr_waddr_i = 0; bus.csr_wdata_i = 0;
    bus.hold_flag_i = HOLD_NONE; bus.jtag_we_i = 0; bus.jtag_addr_i = 0; bus.jtag_data_i = 0;
    bus.lk_addr_i = 0;
  endtask

  // Reset, then one idle cycle so the next bundle is consumed
  task automatic do_reset();
    rst = 1; drive_idle(); settle(); advance();
    rst = 0; settle(); advance();
  endtask

  function automatic logic [OUTW-1:0] act_vec();
    return {bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.csr_we_o, bus.csr_waddr_o,
            bus.csr_wdata_o, bus.lk_hit_o, bus.lk_data_o, bus.hold_req_o, bus.retire_o,
            bus.retire_pc_o, bus.ovf_o, bus.instret_o};
  endfunction

  task automatic test_reset();
    logic [OUTW-1:0] a;
    rst = 1; drive_idle(); bus.hold_flag_i = 3'd7; bus.lk_addr_i = 5'd3;
    settle(); a = act_vec();
    checks++; if (a !== '0) begin errors++; $display("FAIL reset.during got=%h exp=0", a); end
    advance(); rst = 0; drive_idle();
    settle(); a = act_vec();
    checks++; if (a !== '0) begin errors++; $display("FAIL reset.after got=%h exp=0", a); end
    advance();
  endtask

  task automatic test_plain_retire();
    do_reset();
    bus.inst_i = 32'h0120_0293; bus.inst_addr_i = 32'h100; bus.reg_we_i = 1;
    bus.reg_waddr_i = 5; bus.reg_wdata_i = 32'h12; bus.lk_addr_i = 5;
    settle();
    checks++; if (bus.rf_we_o !== 1'b1) begin errors++; $display("FAIL plain.rf_we got=%0h exp=1", bus.rf_we_o); end
    checks++; if (bus.rf_waddr_o !== 5'd5) begin errors++; $display("FAIL plain.rf_waddr got=%0h exp=5", bus.rf_waddr_o); end
    checks++; if (bus.rf_wdata_o !== 32'h12) begin errors++; $display("FAIL plain.rf_wdata got=%0h exp=12", bus.rf_wdata_o); end
    checks++; if (bus.retire_o !== 1'b1) begin errors++; $display("FAIL plain.retire got=%0h exp=1", bus.retire_o); end
    checks++; if (bus.retire_pc_o !== 32'h100) begin errors++; $display("FAIL plain.pc got=%0h exp=100", bus.retire_pc_o); end
    checks++; if (bus.lk_hit_o !== 1'b0) begin errors++; $display("FAIL plain.lk_hit got=%0h exp=0", bus.lk_hit_o); end
    checks++; if (bus.instret_o !== CNT_W'(0)) begin errors++; $display("FAIL plain.instret0 got=%0h exp=0", bus.instret_o); end
    advance(); drive_idle(); settle();
    checks++; if (bus.instret_o !== CNT_W'(IR_EN)) begin errors++; $display("FAIL plain.instret1 got=%0h exp=%0h", bus.instret_o, IR_EN); end
    checks++; if (bus.rf_we_o !== 1'b0 || bus.retire_o !== 1'b0) begin errors++; $display("FAIL plain.idle got=%0h%0h exp=00", bus.rf_we_o, bus.retire_o); end
    advance();
  endtask

  task automatic test_hold_repeat();
    int n_we = 0, n_ret = 0;
    do_reset();
    bus.inst_i = 32'h0770_0393; bus.inst_addr_i = 32'h200; bus.reg_we_i = 1;
    bus.reg_waddr_i = 7; bus.reg_wdata_i = 32'h77;
    for (int k = 0; k < 3; k++) begin
      bus.hold_flag_i = (k < 2) ? HOLD_MEM : HOLD_NONE;
      settle();
      n_we += int'(bus.rf_we_o); n_ret += int'(bus.retire_o);
      advance();
    end
    drive_idle(); settle();
    checks++; if (n_we != 1) begin errors++; $display("FAIL hold.writes got=%0d exp=1", n_we); end
    checks++; if (n_ret != 1) begin errors++; $display("FAIL hold.retires got=%0d exp=1", n_ret); end
    checks++; if (bus.instret_o !== CNT_W'(IR_EN)) begin errors++; $display("FAIL hold.instret got=%0h exp=%0h", bus.instret_o, IR_EN); end
    advance();
  endtask

  task automatic test_collision();
    do_reset();
    bus.jtag_we_i = 1; bus.jtag_addr_i = 7; bus.jtag_data_i = 32'hAA;
    bus.inst_i = 32'h0550_0193; bus.reg_we_i = 1; bus.reg_waddr_i = 3; bus.reg_wdata_i = 32'h55;
    bus.lk_addr_i = 3;
    settle();
    checks++; if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, 5'd7, 32'hAA}) begin errors++; $display("FAIL coll.c0_rf got=%0h/%0h/%0h exp=1/7/aa", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
    checks++; if ({bus.lk_hit_o, bus.lk_data_o} !== {1'b1, 32'h55}) begin errors++; $display("FAIL coll.c0_lk got=%0h/%0h exp=1/55", bus.lk_hit_o, bus.lk_data_o); end
    checks++; if (bus.hold_req_o !== 1'b0) begin errors++; $display("FAIL coll.c0_hold got=%0h exp=0", bus.hold_req_o); end
    advance(); drive_idle(); bus.lk_addr_i = 3; settle();
    checks++; if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, 5'd3, 32'h55}) begin errors++; $display("FAIL coll.c1_rf got=%0h/%0h/%0h exp=1/3/55", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
    checks++; if ({bus.lk_hit_o, bus.lk_data_o} !== {1'b1, 32'h55}) begin errors++; $display("FAIL coll.c1_lk got=%0h/%0h exp=1/55", bus.lk_hit_o, bus.lk_data_o); end
    checks++; if (bus.hold_req_o !== 1'b1) begin errors++; $display("FAIL coll.c1_hold got=%0h exp=1", bus.hold_req_o); end
    advance(); settle();
    checks++; if ({bus.hold_req_o, bus.rf_we_o, bus.lk_hit_o} !== 3'b000) begin errors++; $display("FAIL coll.c2 got=%b exp=000", {bus.hold_req_o, bus.rf_we_o, bus.lk_hit_o}); end
    advance();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      bus.jtag_we_i = 1; bus.jtag_addr_i = 5'(10 + k); bus.jtag_data_i = 32'(k);
      bus.inst_i = 32'h0000_0033; bus.reg_we_i = 1; bus.reg_waddr_i = 5'(k); bus.reg_wdata_i = 32'h100 + 32'(k);
      settle();
      checks++; if (bus.rf_waddr_o !== 5'(10 + k)) begin errors++; $display("FAIL ovf.jtag%0d got=%0h exp=%0h", k, bus.rf_waddr_o, 10 + k); end
      checks++; if (bus.ovf_o !== (k > 3)) begin errors++; $display("FAIL ovf.flag%0d got=%0h exp=%0h", k, bus.ovf_o, k > 3); end
      advance();
    end
    drive_idle();
    for (int k = 1; k <= 2; k++) begin
      settle();
      checks++; if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, 5'(k), 32'h100 + 32'(k)}) begin errors++; $display("FAIL ovf.drain%0d got=%0h/%0h/%0h", k, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
      advance();
    end
    settle();
    checks++; if ({bus.rf_we_o, bus.hold_req_o, bus.ovf_o} !== 3'b001) begin errors++; $display("FAIL ovf.end got=%b exp=001", {bus.rf_we_o, bus.hold_req_o, bus.ovf_o}); end
    advance();
  endtask

  task automatic test_nop_x0();
    do_reset();
    bus.inst_i = INST_NOP; bus.inst_addr_i = 32'h300;
    settle();
    checks++; if (bus.retire_o !== 1'b0) begin errors++; $display("FAIL nop.retire got=%0h exp=0", bus.retire_o); end
    advance();
    bus.inst_i = 32'h0010_0013; bus.reg_we_i = 1; bus.reg_waddr_i = 0; bus.reg_wdata_i = 32'hDEAD;
    settle();
    checks++; if ({bus.retire_o, bus.rf_we_o} !== 2'b10) begin errors++; $display("FAIL x0.direct got=%b exp=10", {bus.retire_o, bus.rf_we_o}); end
    advance();
    bus.jtag_we_i = 1; bus.jtag_addr_i = 9; bus.jtag_data_i = 32'h99;
    settle(); advance(); drive_idle(); settle();
    checks++; if ({bus.hold_req_o, bus.rf_we_o} !== 2'b00) begin errors++; $display("FAIL x0.nobuf got=%b exp=00", {bus.hold_req_o, bus.rf_we_o}); end
    checks++; if (bus.instret_o !== CNT_W'(IR_EN ? 2 : 0)) begin errors++; $display("FAIL x0.instret got=%0h exp=%0h", bus.instret_o, IR_EN ? 2 : 0); end
    advance();
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int k = 1; k <= 2; k++) begin
      bus.jtag_we_i = 1; bus.jtag_addr_i = 20; bus.inst_i = 32'h0000_0033;
      bus.reg_we_i = 1; bus.reg_waddr_i = 5'(k); bus.reg_wdata_i = 32'(k);
      settle(); advance();
    end
    rst = 1; drive_idle(); bus.lk_addr_i = 1; settle();
    checks++; if ({bus.rf_we_o, bus.lk_hit_o} !== 2'b00) begin errors++; $display("FAIL rstd.during got=%b exp=00", {bus.rf_we_o, bus.lk_hit_o}); end
    advance(); rst = 0; settle();
    checks++; if ({bus.hold_req_o, bus.rf_we_o, bus.lk_hit_o, bus.ovf_o} !== 4'b0000) begin errors++; $display("FAIL rstd.after got=%b exp=0000", {bus.hold_req_o, bus.rf_we_o, bus.lk_hit_o, bus.ovf_o}); end
    checks++; if (bus.instret_o !== CNT_W'(0)) begin errors++; $display("FAIL rstd.instret got=%0h exp=0", bus.instret_o); end
    advance(); settle();
    checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL rstd.nodrain got=%0h exp=0", bus.rf_we_o); end
    advance();
  endtask

  task automatic test_random();
    logic [OUTW-1:0] a, e;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.inst_i      = ($urandom_range(0, 4) == 0) ? INST_NOP : 32'($urandom);
      bus.inst_addr_i = 32'($urandom);
      bus.reg_we_i    = ($urandom_range(0, 3) != 0);
      bus.reg_waddr_i = 5'($urandom_range(0, 7));
      bus.reg_wdata_i = 32'($urandom);
      bus.csr_we_i    = ($urandom_range(0, 3) == 0);
      bus.csr_waddr_i = 32'($urandom);
      bus.csr_wdata_i = 32'($urandom);
      bus.hold_flag_i = 3'($urandom_range(0, 7));
      bus.jtag_we_i   = ($urandom_range(0, 2) == 0);
      bus.jtag_addr_i = 5'($urandom_range(0, 7));
      bus.jtag_data_i = 32'($urandom);
      bus.lk_addr_i   = 5'($urandom_range(0, 7));
      settle();
      a = act_vec();
      e = {e_rf_we, e_rf_addr, e_rf_data, e_csr_we, e_csr_addr, e_csr_data, e_hit, e_lkd,
           m_hold, e_ret, e_pc, m_ovf, m_ir};
      checks++;
      if (a !== e) begin errors++; $display("FAIL rand[%0d] got=%h exp=%h", n, a, e); end
      advance();
    end
    rst = 0; drive_idle();
  endtask

  initial begin
    rst = 1;
    drive_idle();
    m_q.delete(); m_new = 0; m_hold = 0; m_ovf = 0; m_ir = 0;
    #1;
    test_reset();
    test_plain_retire();
    test_hold_repeat();
    test_collision();
    test_overflow();
    test_nop_x0();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
